analog_power_fsm: RTL and testbench

- Board-level control block that switches the analog front-end supply on and off in response to single-byte ASCII commands from the UART receive path.
- 'P' (0x50) requests power on; 'p' (0x70) requests power off.
- A global OutputEnable qualifies the physical enable pin, so the supply can be forced off without losing the requested state.
- Sits between the UART RX byte bus and the analog regulator enable pin.

---
 rtl/analog_power_fsm_if.sv | 21 ++
 rtl/analog_power_fsm.sv | 47 ++++
 tb/tb_analog_power_fsm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/analog_power_fsm_if.sv
// UART RX command byte, global output qualifier and regulator enable,
// grouped as one interface between the command source and the power FSM.
interface analog_power_fsm_if;
    logic [7:0] Cmd;
    logic       OutputEnable;
    logic       AnalogPowerEnable;

    // Command source / board side: drives the byte and the qualifier, observes the enable pin.
    modport master (
        output Cmd,
        output OutputEnable,
        input  AnalogPowerEnable
    );

    // Power FSM side.
    modport slave (
        input  Cmd,
        input  OutputEnable,
        output AnalogPowerEnable
    );
endinterface : analog_power_fsm_if

// File: rtl/analog_power_fsm.sv
// Analog front-end supply control. 'P' turns the supply on, 'p' turns it
// off; any other byte, including a floating bus, leaves the state alone.
// OutputEnable gates the pin combinationally without disturbing the
// recorded request, so re-enabling restores the last requested state.
module analog_power_fsm #(
    parameter logic [7:0] CMD_ON  = 8'h50,
    parameter logic [7:0] CMD_OFF = 8'h70
) (
    input  logic                  Clock,
    input  logic                  Reset,
    analog_power_fsm_if.slave     bus
);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // State register: asynchronous clear to OFF, release takes effect on the next rising edge.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: exact byte match; a case item never matches X/Z bits,
    // so an unknown byte falls into default and the state holds.
    // NOTE: the default is assigned before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (bus.Cmd)
            CMD_ON:  w_next_state = ST_ON;
            CMD_OFF: w_next_state = ST_OFF;
            default: w_next_state = r_state;
        endcase
    end

    // Regulator enable: purely combinational so OutputEnable drops the supply without a clock.
    assign bus.AnalogPowerEnable = (r_state == ST_ON) && bus.OutputEnable;

endmodule : analog_power_fsm

// File: tb/tb_analog_power_fsm.sv
// Directed bench for analog_power_fsm: reset, gated commands, on/off,
// ignored bytes, asynchronous OutputEnable and mid-cycle reset.
`timescale 1ns/1ps
module tb_analog_power_fsm;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    analog_power_fsm_if u_if ();

    analog_power_fsm #(
        .CMD_ON  (8'h50),
        .CMD_OFF (8'h70)
    ) u_dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (u_if.slave)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic expect_en(input string name, input logic exp);
        checks++;
        if (u_if.AnalogPowerEnable !== exp) begin
            errors++;
            $display("FAIL %s: AnalogPowerEnable=%b expected %b at %0t",
                     name, u_if.AnalogPowerEnable, exp, $time);
        end
    endtask

    // Drive Cmd mid-cycle, then look 1 ns after the edge that samples it.
    task automatic send(input logic [7:0] cmd);
        @(negedge Clock);
        u_if.Cmd = cmd;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        u_if.Cmd = 8'h50;
        u_if.OutputEnable = 1'b1;
        #1;
        expect_en("reset_initial", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            expect_en("reset_held_with_cmd_on", 1'b0);
        end
        @(negedge Clock);
        Reset = 1'b1;
        u_if.Cmd = 8'h00;
        @(posedge Clock);
        #1;
        expect_en("reset_release_idle", 1'b0);
        @(posedge Clock);
        #1;
        expect_en("reset_release_idle2", 1'b0);
    endtask

    task automatic test_gated_command();
        @(negedge Clock);
        u_if.OutputEnable = 1'b0;
        send(8'h50);
        expect_en("gated_cmd_on", 1'b0);
        send(8'hzz);
        expect_en("gated_cmd_float", 1'b0);
        u_if.OutputEnable = 1'b1;
        #1;
        expect_en("gated_oe_rise_immediate", 1'b1);
        send(8'h70);
        expect_en("gated_cleanup_off", 1'b0);
    endtask

    task automatic test_on_off();
        send(8'h50);
        expect_en("onoff_on", 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) send(8'hzz);
            else            send(8'hxx);
            expect_en("onoff_hold_unknown", 1'b1);
        end
        send(8'h70);
        expect_en("onoff_off", 1'b0);
    endtask

    task automatic test_ignore_nonmatching();
        logic [7:0] seq [7];
        logic       exp [7];
        seq = '{8'h50, 8'h50, 8'h51, 8'h10, 8'h7F, 8'h70, 8'h70};
        exp = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        for (int i = 0; i < 7; i++) begin
            send(seq[i]);
            expect_en($sformatf("ignore_seq%0d_%02h", i, seq[i]), exp[i]);
        end
    endtask

    task automatic test_oe_async();
        send(8'h50);
        expect_en("oe_state_on", 1'b1);
        u_if.Cmd = 8'h00;
        @(posedge Clock);
        #3;
        u_if.OutputEnable = 1'b0;
        #1;
        expect_en("oe_drop_no_edge", 1'b0);
        u_if.OutputEnable = 1'b1;
        #0.5;
        expect_en("oe_reassert", 1'b1);
        // OutputEnable falls on the same edge that samples CMD_ON.
        send(8'h70);
        expect_en("oe_setup_off", 1'b0);
        @(negedge Clock);
        u_if.Cmd = 8'h50;
        @(posedge Clock);
        u_if.OutputEnable = 1'b0;
        #1;
        expect_en("oe_fall_with_cmd_on", 1'b0);
        u_if.Cmd = 8'h00;
        u_if.OutputEnable = 1'b1;
        #1;
        expect_en("oe_state_recorded_on", 1'b1);
    endtask

    task automatic test_async_reset_mid();
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        expect_en("midreset_immediate", 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            expect_en("midreset_stays_off", 1'b0);
        end
        send(8'h50);
        expect_en("midreset_new_on", 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_gated_command();
        test_on_off();
        test_ignore_nonmatching();
        test_oe_async();
        test_async_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_analog_power_fsm
